// File: rtl/countdown_timer.sv
// Countdown timer with BCD mm:ss display digits.
// Counts down one second per i_sec_tick while running, raises a one-cycle
// o_done pulse on reaching 00:00 and holds o_alarm until acknowledged.
module countdown_timer #(
  parameter int unsigned SEC_T_MAX = 5,
  parameter int unsigned DIG_MAX   = 9
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_sec_tick,
  input  logic       i_load,
  input  logic [3:0] i_min_t,
  input  logic [3:0] i_min_u,
  input  logic [3:0] i_sec_t,
  input  logic [3:0] i_sec_u,
  input  logic       i_start_stop,
  input  logic       i_clear,
  output logic [3:0] o_min_t,
  output logic [3:0] o_min_u,
  output logic [3:0] o_sec_t,
  output logic [3:0] o_sec_u,
  output logic       o_running,
  output logic       o_done,
  output logic       o_alarm
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] SEC_T_LIM = 4'(SEC_T_MAX);
  localparam logic [3:0] DIG_LIM   = 4'(DIG_MAX);

  // Count is kept packed as {min_t, min_u, sec_t, sec_u}.
  state_t      state;
  state_t      state_nxt;
  logic [15:0] cnt;
  logic [15:0] cnt_nxt;
  logic [15:0] cnt_dec;
  logic        done_nxt;

  // Clamp a single preset digit to its maximum.
  function automatic logic [3:0] sat_digit(input logic [3:0] d, input logic [3:0] lim);
    sat_digit = (d > lim) ? lim : d;
  endfunction

  // Saturate all four preset digits into a legal count.
  function automatic logic [15:0] sat_preset(input logic [3:0] mt, input logic [3:0] mu,
                                             input logic [3:0] st, input logic [3:0] su);
    sat_preset = {sat_digit(mt, DIG_LIM), sat_digit(mu, DIG_LIM),
                  sat_digit(st, SEC_T_LIM), sat_digit(su, DIG_LIM)};
  endfunction

  // Subtract one second with BCD borrow; only called on a non-zero count.
  function automatic logic [15:0] dec_count(input logic [15:0] c);
    logic [3:0] mt, mu, st, su;
    {mt, mu, st, su} = c;
    if (su != 4'd0) begin
      su = su - 4'd1;
    end else begin
      su = DIG_LIM;
      if (st != 4'd0) begin
        st = st - 4'd1;
      end else begin
        st = SEC_T_LIM;
        if (mu != 4'd0) begin
          mu = mu - 4'd1;
        end else begin
          mu = DIG_LIM;
          mt = mt - 4'd1;
        end
      end
    end
    dec_count = {mt, mu, st, su};
  endfunction

  assign cnt_dec = dec_count(cnt);

  // Next-state and next-count selection in event priority order:
  // clear, load, start/stop, second tick.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    if (i_clear) begin
      cnt_nxt   = 16'h0000;
      state_nxt = IDLE;
    end else if (i_load && (state != RUN)) begin
      cnt_nxt   = sat_preset(i_min_t, i_min_u, i_sec_t, i_sec_u);
      state_nxt = IDLE;
    end else if (i_start_stop) begin
      case (state)
        IDLE:    state_nxt = (cnt != 16'h0000) ? RUN : IDLE;
        RUN:     state_nxt = PAUSE;
        PAUSE:   state_nxt = RUN;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end else if (i_sec_tick && (state == RUN)) begin
      cnt_nxt = cnt_dec;
      if (cnt_dec == 16'h0000) begin
        state_nxt = DONE;
        done_nxt  = 1'b1;
      end
    end
  end

  // State, count and registered status outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      cnt       <= 16'h0000;
      o_running <= 1'b0;
      o_done    <= 1'b0;
      o_alarm   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      o_running <= (state_nxt == RUN);
      o_done    <= done_nxt;
      o_alarm   <= (state_nxt == DONE);
    end
  end

  assign {o_min_t, o_min_u, o_sec_t, o_sec_u} = cnt;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer.
module tb_countdown_timer;

  logic       clk;
  logic       rst_n;
  logic       sec_tick;
  logic       load;
  logic [3:0] min_t_in, min_u_in, sec_t_in, sec_u_in;
  logic       start_stop;
  logic       clear;
  logic [3:0] min_t, min_u, sec_t, sec_u;
  logic       running, done, alarm;

  int checks = 0;
  int errors = 0;

  countdown_timer #(.SEC_T_MAX(5), .DIG_MAX(9)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_sec_tick   (sec_tick),
    .i_load       (load),
    .i_min_t      (min_t_in),
    .i_min_u      (min_u_in),
    .i_sec_t      (sec_t_in),
    .i_sec_u      (sec_u_in),
    .i_start_stop (start_stop),
    .i_clear      (clear),
    .o_min_t      (min_t),
    .o_min_u      (min_u),
    .o_sec_t      (sec_t),
    .o_sec_u      (sec_u),
    .o_running    (running),
    .o_done       (done),
    .o_alarm      (alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of controls, sample 1 ns after the edge, then drop pulses.
  task automatic cyc(input logic ld, input logic ss, input logic tk, input logic clr);
    load = ld; start_stop = ss; sec_tick = tk; clear = clr;
    @(posedge clk);
    #1;
    load = 1'b0; start_stop = 1'b0; sec_tick = 1'b0; clear = 1'b0;
  endtask

  task automatic preset(input logic [15:0] p);
    {min_t_in, min_u_in, sec_t_in, sec_u_in} = p;
  endtask

  task automatic chk(input string tag, input logic [15:0] exp_cnt,
                     input logic exp_run, input logic exp_done, input logic exp_alarm);
    logic [15:0] obs_cnt;
    logic [2:0]  obs_flags;
    logic [2:0]  exp_flags;
    obs_cnt   = {min_t, min_u, sec_t, sec_u};
    obs_flags = {running, done, alarm};
    exp_flags = {exp_run, exp_done, exp_alarm};
    checks++;
    assert ((obs_cnt === exp_cnt) && (obs_flags === exp_flags)) else begin
      errors++;
      $error("FAIL %s: observed count %h run/done/alarm %b, expected count %h run/done/alarm %b",
             tag, obs_cnt, obs_flags, exp_cnt, exp_flags);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    load = 1'b0; start_stop = 1'b0; sec_tick = 1'b0; clear = 1'b0;
    preset(16'h0000);
    #2;
    chk("reset_state", 16'h0000, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 00:03 countdown to done
    preset(16'h0003);
    cyc(1, 0, 0, 0); chk("load_0003", 16'h0003, 0, 0, 0);
    cyc(0, 0, 1, 0); chk("tick_in_idle", 16'h0003, 0, 0, 0);
    cyc(0, 1, 0, 0); chk("start_0003", 16'h0003, 1, 0, 0);
    cyc(0, 0, 1, 0); chk("tick1_0002", 16'h0002, 1, 0, 0);
    cyc(0, 0, 0, 0); chk("no_tick_hold", 16'h0002, 1, 0, 0);
    cyc(0, 0, 1, 0); chk("tick2_0001", 16'h0001, 1, 0, 0);
    cyc(0, 0, 1, 0); chk("tick3_done", 16'h0000, 0, 1, 1);
    cyc(0, 0, 1, 0); chk("done_pulse_ends", 16'h0000, 0, 0, 1);
    cyc(0, 1, 0, 0); chk("ack_done_idle", 16'h0000, 0, 0, 0);
    cyc(0, 1, 0, 0); chk("start_at_zero", 16'h0000, 0, 0, 0);

    // 10:00 full borrow chain
    preset(16'h1000);
    cyc(1, 0, 0, 0); chk("load_1000", 16'h1000, 0, 0, 0);
    cyc(0, 1, 0, 0); chk("start_1000", 16'h1000, 1, 0, 0);
    cyc(0, 0, 1, 0); chk("borrow_0959", 16'h0959, 1, 0, 0);
    cyc(0, 0, 1, 0); chk("tick_0958", 16'h0958, 1, 0, 0);

    // pause / resume from 00:05
    preset(16'h0005);
    cyc(0, 0, 0, 1); chk("clear_in_run", 16'h0000, 0, 0, 0);
    cyc(1, 0, 0, 0); chk("load_0005", 16'h0005, 0, 0, 0);
    cyc(0, 1, 0, 0); chk("start_0005", 16'h0005, 1, 0, 0);
    cyc(0, 0, 1, 0); chk("tick_0004", 16'h0004, 1, 0, 0);
    cyc(0, 0, 1, 0); chk("tick_0003", 16'h0003, 1, 0, 0);
    cyc(0, 1, 1, 0); chk("pause_with_tick", 16'h0003, 0, 0, 0);
    cyc(0, 0, 1, 0); chk("pause_tick1", 16'h0003, 0, 0, 0);
    cyc(0, 0, 1, 0); chk("pause_tick2", 16'h0003, 0, 0, 0);
    cyc(0, 0, 1, 0); chk("pause_tick3", 16'h0003, 0, 0, 0);
    cyc(0, 1, 0, 0); chk("resume", 16'h0003, 1, 0, 0);
    cyc(0, 0, 1, 0); chk("resume_tick_0002", 16'h0002, 1, 0, 0);

    // load ignored while running
    preset(16'h0707);
    cyc(1, 0, 0, 0); chk("load_ignored_run", 16'h0002, 1, 0, 0);

    // preset saturation
    cyc(0, 0, 0, 1); chk("clear_again", 16'h0000, 0, 0, 0);
    preset(16'h9F7C);
    cyc(1, 0, 0, 0); chk("load_saturate", 16'h9959, 0, 0, 0);

    // asynchronous reset mid-run
    preset(16'h0431);
    cyc(1, 0, 0, 0); chk("load_0431", 16'h0431, 0, 0, 0);
    cyc(0, 1, 0, 0); chk("start_0431", 16'h0431, 1, 0, 0);
    cyc(0, 0, 1, 0); chk("tick_0430", 16'h0430, 1, 0, 0);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_now", 16'h0000, 0, 0, 0);
    sec_tick = 1'b1;
    @(posedge clk); #1;
    sec_tick = 1'b0;
    chk("reset_held", 16'h0000, 0, 0, 0);
    rst_n = 1'b1;
    preset(16'h0001);
    cyc(1, 0, 0, 0); chk("post_reset_load", 16'h0001, 0, 0, 0);
    cyc(0, 1, 0, 0); chk("post_reset_start", 16'h0001, 1, 0, 0);
    cyc(0, 0, 1, 0); chk("post_reset_done", 16'h0000, 0, 1, 1);

    // load from DONE, then clear beats load
    preset(16'h1234);
    cyc(1, 0, 0, 0); chk("load_from_done", 16'h1234, 0, 0, 0);
    preset(16'h0505);
    cyc(1, 0, 0, 1); chk("clear_beats_load", 16'h0000, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter SEC_T_MAX, default 5, SHALL be the maximum seconds-tens digit, used for borrow reload and load saturation.
REQ-002 Parameter DIG_MAX, default 9, SHALL be the maximum value of every other digit.
REQ-003 i_clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 i_rst_n  in  1  SHALL be the reset, asynchronous and active-low.
REQ-005 i_sec_tick  in  1  SHALL be a one-cycle 1 Hz enable pulse from the upstream prescaler.
REQ-006 i_load  in  1  SHALL load the preset digits (level sampled each cycle).
REQ-007 i_min_t, i_min_u, i_sec_t, i_sec_u  in  4 each  SHALL be the BCD preset digits.
REQ-008 i_start_stop  in  1  SHALL be a one-cycle, already-debounced start/pause/acknowledge request.
REQ-009 i_clear  in  1  SHALL be a synchronous clear.
REQ-010 o_min_t, o_min_u, o_sec_t, o_sec_u  out  4 each  SHALL be the registered current BCD count.
REQ-011 o_running  out  1  SHALL be high exactly while in RUN.
REQ-012 o_done  out  1  SHALL be a registered one-cycle pulse on reaching 00:00 from RUN.
REQ-013 o_alarm  out  1  SHALL be high exactly while in DONE.

Function
REQ-014 FSM SHALL have states IDLE, RUN, PAUSE, DONE.
REQ-015 Per-cycle priority: i_clear > i_load > i_start_stop > i_sec_tick.
REQ-016 i_clear in any state: digits <= 0, state <= IDLE, o_done <= 0 next edge.
REQ-017 i_load in IDLE, PAUSE or DONE: capture presets, state <= IDLE; in RUN, ignore i_load.
REQ-018 Load saturation: sec_t > SEC_T_MAX -> SEC_T_MAX; any other digit > DIG_MAX -> DIG_MAX.
REQ-019 IDLE + i_start_stop: count non-zero -> RUN; count 00:00 -> stay IDLE.
REQ-020 RUN + i_start_stop -> PAUSE, no decrement that cycle even if i_sec_tick high.
REQ-021 PAUSE + i_start_stop -> RUN; i_sec_tick ignored in PAUSE.
REQ-022 DONE + i_start_stop -> IDLE, digits stay 00:00.
REQ-023 RUN + i_sec_tick (no higher-priority event): decrement count by one second, same edge.
REQ-024 Borrow chain: sec_u 0 -> DIG_MAX, borrow; sec_t 0 -> SEC_T_MAX, borrow; min_u 0 -> DIG_MAX, borrow; min_t decrements.
REQ-025 Decrement yielding 00:00: state <= DONE and o_done <= 1 on the same edge; o_done cleared next edge.
REQ-026 No wrap below 00:00: RUN is never entered or kept with count 00:00.
REQ-027 i_sec_tick outside RUN SHALL have no effect.
REQ-028 o_done SHALL pulse at most once per RUN->DONE transition.

Reset
REQ-029 On i_rst_n low, immediately: all digits 0, state IDLE, o_running, o_done, o_alarm 0.
REQ-030 Reset mid-RUN SHALL abort the countdown without an o_done pulse.
REQ-031 After i_rst_n deasserts, normal operation resumes on the first rising edge.

Verification
REQ-032 Load 00:03, start, 3 ticks -> 00:02, 00:01, 00:00; o_done one cycle on 3rd tick edge; o_alarm high.
REQ-033 Load 10:00, start, 1 tick -> 09:59 (full borrow chain).
REQ-034 Load 00:05, start, 2 ticks, start_stop with tick same cycle -> PAUSE at 00:03; 3 ticks -> still 00:03; start_stop, tick -> 00:02.
REQ-035 Load preset 9F:7C (sec_t 7, sec_u 12, min_u 15) -> count 99:59.
REQ-036 Start with count 00:00 -> stays IDLE, o_running 0; DONE + start_stop -> IDLE, o_alarm 0.
REQ-037 Reset asserted mid-RUN at 04:30 -> 00:00, IDLE, no o_done; i_clear with i_load same cycle -> 00:00.
